// File: rtl/inst_loader_pkg.sv
// Shared constants and types for the instruction loader: BRAM geometry,
// core mode encodings and the loader FSM state type.
package inst_loader_pkg;

    localparam int          INST_SIZE  = 4;
    localparam int unsigned INST_DEPTH = 1 << INST_SIZE;

    localparam logic [2:0] MODE_STALL = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_EXEC  = 3'd2;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_HDR,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } loader_state_e;

endpackage

// File: rtl/inst_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling timer and
// LSB-first shifter. Held idle while en is low.
module loader_uart_rx #(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int            CW   = $clog2(2 * CLK_PER_HALF_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] FULL = CW'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic          rx;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    assign rx = sync_q[1];

    // The synchronizer resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sync_q    <= {sync_q[0], rxd};
            rx_prev_q <= rx;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (!en) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx) begin
                        state_d = RX_START;
                        cnt_d   = '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL) begin
                        cnt_d   = '0;
                        shift_d = {rx, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = RX_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL) begin
                        cnt_d        = '0;
                        state_d      = RX_IDLE;
                        byte_valid_d = rx;
                        frame_err_d  = !rx;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: receives a length-prefixed little-endian program over
// UART in LOAD mode and writes it word by word into INST_BRAM port A.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2:0]           mode,
    input  logic                 rxd,
    output logic [INST_SIZE-1:0] addra,
    output logic [31:0]          dina,
    output logic                 wea,
    output logic                 done,
    output logic                 err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       load_en;

    loader_state_e        state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [31:0]          asm_q, asm_d, asm_next;
    logic [INST_SIZE:0]   n_q, n_d;
    logic [INST_SIZE:0]   idx_q, idx_d;
    logic [INST_SIZE-1:0] addra_q, addra_d;
    logic [31:0]          dina_q, dina_d;
    logic                 wea_q, wea_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    assign load_en = (mode == MODE_LOAD);

    loader_uart_rx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .en        (load_en),
        .rxd       (rxd),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // Little-endian assembly: each new byte enters at the top and shifts down.
    assign asm_next = {byte_data, asm_q[31:8]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        n_d        = n_q;
        idx_d      = idx_q;
        addra_d    = addra_q;
        dina_d     = dina_q;
        wea_d      = 1'b0;
        done_d     = (state_q == LD_DONE);
        err_d      = (state_q == LD_ERR);
        unique case (state_q)
            LD_IDLE: begin
                if (load_en && !done_q) begin
                    state_d    = LD_HDR;
                    byte_cnt_d = '0;
                    idx_d      = '0;
                end
            end
            LD_HDR, LD_DATA: begin
                // Leaving LOAD outranks a byte completing in the same cycle.
                if (!load_en) begin
                    state_d    = LD_IDLE;
                    byte_cnt_d = '0;
                    idx_d      = '0;
                end else if (frame_err) begin
                    state_d = LD_ERR;
                end else if (byte_valid) begin
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == LD_HDR) begin
                            if (asm_next == 32'd0) begin
                                state_d = LD_DONE;
                            end else if (asm_next > INST_DEPTH) begin
                                state_d = LD_ERR;
                            end else begin
                                state_d = LD_DATA;
                                n_d     = asm_next[INST_SIZE:0];
                                idx_d   = '0;
                            end
                        end else begin
                            wea_d   = 1'b1;
                            dina_d  = asm_next;
                            addra_d = idx_q[INST_SIZE-1:0];
                            idx_d   = idx_q + 1'b1;
                            if ((idx_q + 1'b1) == n_q) state_d = LD_DONE;
                        end
                    end
                end
            end
            LD_DONE, LD_ERR: ;
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= LD_IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            addra_q    <= '0;
            dina_q     <= '0;
            wea_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            wea_q      <= wea_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign addra = addra_q;
    assign dina  = dina_q;
    assign wea   = wea_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: directed protocol cases plus random
// programs, BRAM writes checked by an independent monitor.
module tb_inst_loader;
    import inst_loader_pkg::*;

    localparam int HB  = 4;
    localparam int BIT = 2 * HB;

    logic                 clk  = 1'b0;
    logic                 rstn = 1'b0;
    logic [2:0]           mode = MODE_STALL;
    logic                 rxd  = 1'b1;
    logic [INST_SIZE-1:0] addra;
    logic [31:0]          dina;
    logic                 wea, done, err;

    always #5 clk = ~clk;

    inst_loader #(.CLK_PER_HALF_BIT(HB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .mode (mode),
        .rxd  (rxd),
        .addra(addra),
        .dina (dina),
        .wea  (wea),
        .done (done),
        .err  (err)
    );

    typedef struct {
        logic [INST_SIZE-1:0] addr;
        logic [31:0]          data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   expect_wea_before_done = 1'b0;
    logic prev_wea = 1'b0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next expected BRAM write.
    always @(negedge clk) begin
        wr_t e;
        if (rstn) begin
            if (wea) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addra=%0d dina=0x%08h", addra, dina);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(addra), 32'(e.addr));
                    check("wr_data", dina, e.data);
                    check("done_low_on_wea", 32'(done), 32'd0);
                end
            end
            if (done && !prev_done)
                check("done_after_last_wea", 32'(prev_wea), 32'(expect_wea_before_done));
        end
        prev_wea  <= wea;
        prev_done <= done;
    end

    task automatic hold_bit(input logic v);
        @(negedge clk);
        rxd = v;
        repeat (BIT - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)));
    endtask

    task automatic wait_flag(input string name, input bit want_err);
        int k = 0;
        while (((want_err ? err : done) !== 1'b1) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(want_err ? err : done), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        mode = MODE_STALL;
        rxd  = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic enter_load();
        mode = MODE_LOAD;
        repeat (3) @(negedge clk);
    endtask

    // Reference: a program of N words lands at addresses 0..N-1 in order, then done.
    task automatic load_program(input string tag, input logic [31:0] words[$]);
        wr_t e;
        expect_wea_before_done = (words.size() > 0);
        send_word(32'(words.size()));
        foreach (words[i]) begin
            e.addr = INST_SIZE'(i);
            e.data = words[i];
            exp_q.push_back(e);
            send_word(words[i]);
        end
        wait_flag({tag, "_done"}, 1'b0);
        repeat (2) @(negedge clk);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] prog[$];

        // Reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addra", 32'(addra), 32'd0);
        check("rst_dina", dina, 32'd0);
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Two-word program
        do_reset();
        enter_load();
        prog = '{32'h1234_5678, 32'hDEAD_BEEF};
        load_program("two_words", prog);

        // Empty program
        do_reset();
        enter_load();
        prog = {};
        load_program("empty", prog);

        // Oversize header (17 > 16)
        do_reset();
        enter_load();
        send_word(32'd17);
        wait_flag("oversize_err", 1'b1);
        check("oversize_done", 32'(done), 32'd0);

        // Framing error on the last byte of word 0
        do_reset();
        enter_load();
        send_word(32'd1);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12, 1'b0);
        wait_flag("frame_err", 1'b1);
        repeat (4) @(negedge clk);
        check("frame_done", 32'(done), 32'd0);

        // Mode leaves LOAD mid-word, then a fresh load
        do_reset();
        enter_load();
        send_word(32'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        mode = MODE_EXEC;
        repeat (20) @(negedge clk);
        check("mode_drop_no_done", 32'(done), 32'd0);
        enter_load();
        prog = '{32'hDDCC_BBAA};
        load_program("reload", prog);

        // Async reset in the middle of word 2
        do_reset();
        enter_load();
        begin
            wr_t e;
            send_word(32'd3);
            e.addr = 1'b0; e.data = 32'hCAFE_0001; exp_q.push_back(e); send_word(e.data);
            e.addr = 1'b1; e.data = 32'hCAFE_0002; exp_q.push_back(e); send_word(e.data);
        end
        send_byte(8'h33);
        hold_bit(1'b0);
        #2 rstn = 1'b0;
        #1;
        check("async_addra", 32'(addra), 32'd0);
        check("async_dina", dina, 32'd0);
        check("async_wea", 32'(wea), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_err", 32'(err), 32'd0);
        check("pre_reset_written", 32'(exp_q.size()), 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        prog = '{32'hA5A5_0000, 32'h5A5A_1111, 32'h0F0F_2222};
        load_program("after_reset", prog);

        // Random programs, first one at full capacity
        for (int it = 0; it < 4; it++) begin
            int n;
            n = (it == 0) ? int'(INST_DEPTH) : int'($urandom_range(1, INST_DEPTH));
            prog = {};
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            do_reset();
            enter_load();
            load_program($sformatf("rand%0d", it), prog);
        end

        // Random oversize header
        do_reset();
        enter_load();
        send_word($urandom_range(INST_DEPTH + 1, 65535));
        wait_flag("rand_oversize_err", 1'b1);
        check("rand_oversize_done", 32'(done), 32'd0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
